// File: rtl/wb_decoder_pkg.sv
// Shared types and constants for the 1:4 Wishbone address decoder.
package wb_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam int unsigned NUM_SLV = 4;

  localparam logic [1:0] SLV1 = 2'd0;
  localparam logic [1:0] SLV2 = 2'd1;
  localparam logic [1:0] SLV3 = 2'd2;
  localparam logic [1:0] SLV4 = 2'd3;

  localparam logic [31:0] ERR_DAT_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_decoder_if.sv
// Upstream Wishbone slave port plus the four downstream master ports of the decoder.
interface wb_decoder_if;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;

  logic        wbm1_cyc_o, wbm1_stb_o, wbm1_we_o, wbm1_ack_i;
  logic [3:0]  wbm1_sel_o;
  logic [31:0] wbm1_adr_o, wbm1_dat_o, wbm1_dat_i;
  logic        wbm2_cyc_o, wbm2_stb_o, wbm2_we_o, wbm2_ack_i;
  logic [3:0]  wbm2_sel_o;
  logic [31:0] wbm2_adr_o, wbm2_dat_o, wbm2_dat_i;
  logic        wbm3_cyc_o, wbm3_stb_o, wbm3_we_o, wbm3_ack_i;
  logic [3:0]  wbm3_sel_o;
  logic [31:0] wbm3_adr_o, wbm3_dat_o, wbm3_dat_i;
  logic        wbm4_cyc_o, wbm4_stb_o, wbm4_we_o, wbm4_ack_i;
  logic [3:0]  wbm4_sel_o;
  logic [31:0] wbm4_adr_o, wbm4_dat_o, wbm4_dat_i;

  // Handshake: upstream request holds cyc/stb until wbs_ack_o (one cycle);
  // downstream cyc/stb stay high until the slave's ack, a timeout or an upstream abort.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output wbm1_cyc_o, wbm1_stb_o, wbm1_we_o, wbm1_sel_o, wbm1_adr_o, wbm1_dat_o,
    input  wbm1_dat_i, wbm1_ack_i,
    output wbm2_cyc_o, wbm2_stb_o, wbm2_we_o, wbm2_sel_o, wbm2_adr_o, wbm2_dat_o,
    input  wbm2_dat_i, wbm2_ack_i,
    output wbm3_cyc_o, wbm3_stb_o, wbm3_we_o, wbm3_sel_o, wbm3_adr_o, wbm3_dat_o,
    input  wbm3_dat_i, wbm3_ack_i,
    output wbm4_cyc_o, wbm4_stb_o, wbm4_we_o, wbm4_sel_o, wbm4_adr_o, wbm4_dat_o,
    input  wbm4_dat_i, wbm4_ack_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  wbm1_cyc_o, wbm1_stb_o, wbm1_we_o, wbm1_sel_o, wbm1_adr_o, wbm1_dat_o,
    output wbm1_dat_i, wbm1_ack_i,
    input  wbm2_cyc_o, wbm2_stb_o, wbm2_we_o, wbm2_sel_o, wbm2_adr_o, wbm2_dat_o,
    output wbm2_dat_i, wbm2_ack_i,
    input  wbm3_cyc_o, wbm3_stb_o, wbm3_we_o, wbm3_sel_o, wbm3_adr_o, wbm3_dat_o,
    output wbm3_dat_i, wbm3_ack_i,
    input  wbm4_cyc_o, wbm4_stb_o, wbm4_we_o, wbm4_sel_o, wbm4_adr_o, wbm4_dat_o,
    output wbm4_dat_i, wbm4_ack_i
  );
endinterface

// File: rtl/wb_watchdog.sv
// Cycle counter for the ISSUE phase; expire_o is registered and high while count_o == TIMEOUT_CYC-1.
module wb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255,
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic          expire_o,
  output logic [TW-1:0] count_o
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  // Counting stops at LAST, so the counter can never wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_o  <= '0;
      expire_o <= (LAST == '0);
    end else if (en_i && !expire_o) begin
      count_o  <= count_o + 1'b1;
      expire_o <= ((count_o + 1'b1) == LAST);
    end
  end
endmodule

// File: rtl/wb_decoder.sv
// One-to-four Wishbone decoder: registered request routing by address window, registered response,
// watchdog abort of cycles a slave never acks.
module wb_decoder
  import wb_decoder_pkg::*;
#(
  parameter logic [31:0] BASE1       = 32'h0000_0000,
  parameter logic [31:0] BASE2       = 32'h1000_0000,
  parameter logic [31:0] BASE3       = 32'h2000_0000,
  parameter logic [31:0] BASE4       = 32'h3000_0000,
  parameter logic [31:0] MASK1       = 32'hF000_0000,
  parameter logic [31:0] MASK2       = 32'hF000_0000,
  parameter logic [31:0] MASK3       = 32'hF000_0000,
  parameter logic [31:0] MASK4       = 32'hF000_0000,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DAT     = ERR_DAT_DEFAULT,
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_decoder_if.slave   bus,
  output state_e        dbg_state,
  output logic [TW-1:0] dbg_timer
);

  state_e state_q, state_d;

  logic [NUM_SLV-1:0] m_cyc, m_we, s_ack;
  logic [3:0]         m_sel [NUM_SLV];
  logic [31:0]        m_adr [NUM_SLV];
  logic [31:0]        m_dat [NUM_SLV];
  logic [31:0]        s_dat [NUM_SLV];

  logic [1:0]  cur_q;
  logic        ack_q, err_q, ack_d, err_d;
  logic [31:0] dat_q, dat_d;
  logic        start, drop, expired;
  logic [2:0]  hit;

  // {hit, index}; checked in slave order so the lowest matching window wins.
  function automatic logic [2:0] decode(input logic [31:0] adr);
    if ((adr & MASK1) == BASE1) return {1'b1, SLV1};
    if ((adr & MASK2) == BASE2) return {1'b1, SLV2};
    if ((adr & MASK3) == BASE3) return {1'b1, SLV3};
    if ((adr & MASK4) == BASE4) return {1'b1, SLV4};
    return 3'b000;
  endfunction

  wb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (state_q != ST_ISSUE),
    .en_i     (state_q == ST_ISSUE),
    .expire_o (expired),
    .count_o  (dbg_timer)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    drop    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    hit     = decode(bus.wbs_adr_i);
    case (state_q)
      ST_IDLE: begin
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          if (hit[2]) begin
            start   = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            dat_d   = ERR_DAT;
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        // Upstream abort outranks everything; an ack on the expiry cycle beats the timeout.
        if (!bus.wbs_cyc_i) begin
          drop    = 1'b1;
          state_d = ST_IDLE;
        end else if (s_ack[cur_q]) begin
          drop    = 1'b1;
          ack_d   = 1'b1;
          dat_d   = m_we[cur_q] ? 32'h0 : s_dat[cur_q];
          state_d = ST_RESP;
        end else if (expired) begin
          drop    = 1'b1;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          dat_d   = ERR_DAT;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cur_q <= '0;
      m_cyc <= '0;
      m_we  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      for (int n = 0; n < NUM_SLV; n++) begin
        m_sel[n] <= '0;
        m_adr[n] <= '0;
        m_dat[n] <= '0;
      end
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
      if (drop) m_cyc <= '0;
      if (start) begin
        cur_q           <= hit[1:0];
        m_cyc           <= 4'b0001 << hit[1:0];
        m_we[hit[1:0]]  <= bus.wbs_we_i;
        m_sel[hit[1:0]] <= bus.wbs_sel_i;
        m_adr[hit[1:0]] <= bus.wbs_adr_i;
        m_dat[hit[1:0]] <= bus.wbs_dat_i;
      end
    end
  end

  assign dbg_state     = state_q;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_err_o = err_q;
  assign bus.wbs_dat_o = dat_q;

  assign s_ack = {bus.wbm4_ack_i, bus.wbm3_ack_i, bus.wbm2_ack_i, bus.wbm1_ack_i};
  assign s_dat[0] = bus.wbm1_dat_i;
  assign s_dat[1] = bus.wbm2_dat_i;
  assign s_dat[2] = bus.wbm3_dat_i;
  assign s_dat[3] = bus.wbm4_dat_i;

  // stb mirrors cyc: only single classic cycles are issued downstream.
  assign bus.wbm1_cyc_o = m_cyc[0];
  assign bus.wbm1_stb_o = m_cyc[0];
  assign bus.wbm1_we_o  = m_we[0];
  assign bus.wbm1_sel_o = m_sel[0];
  assign bus.wbm1_adr_o = m_adr[0];
  assign bus.wbm1_dat_o = m_dat[0];
  assign bus.wbm2_cyc_o = m_cyc[1];
  assign bus.wbm2_stb_o = m_cyc[1];
  assign bus.wbm2_we_o  = m_we[1];
  assign bus.wbm2_sel_o = m_sel[1];
  assign bus.wbm2_adr_o = m_adr[1];
  assign bus.wbm2_dat_o = m_dat[1];
  assign bus.wbm3_cyc_o = m_cyc[2];
  assign bus.wbm3_stb_o = m_cyc[2];
  assign bus.wbm3_we_o  = m_we[2];
  assign bus.wbm3_sel_o = m_sel[2];
  assign bus.wbm3_adr_o = m_adr[2];
  assign bus.wbm3_dat_o = m_dat[2];
  assign bus.wbm4_cyc_o = m_cyc[3];
  assign bus.wbm4_stb_o = m_cyc[3];
  assign bus.wbm4_we_o  = m_we[3];
  assign bus.wbm4_sel_o = m_sel[3];
  assign bus.wbm4_adr_o = m_adr[3];
  assign bus.wbm4_dat_o = m_dat[3];

endmodule

// File: tb/tb_wb_decoder.sv
// Randomized bench for wb_decoder against a transaction-level response model (TIMEOUT_CYC = 8).
module tb_wb_decoder;
  import wb_decoder_pkg::*;

  localparam int          TIMEOUT = 8;
  localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;
  localparam int          EW      = 56;
  localparam logic [31:0] BASES [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
  localparam logic [31:0] MASKS [4] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  state_e     dbg_state;
  logic [3:0] dbg_timer;

  wb_decoder_if bus ();

  wb_decoder #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_timer (dbg_timer)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL sim_time_limit got=hang exp=finish");
    $fatal(1, "time limit");
  end

  // ---------------- bus views ----------------
  logic [3:0]  m_cyc, m_stb, m_we;
  logic [3:0]  m_sel [4];
  logic [31:0] m_adr [4];
  logic [31:0] m_dat [4];
  logic [3:0]  s_ack;
  logic [31:0] s_dat [4];

  assign m_cyc = {bus.wbm4_cyc_o, bus.wbm3_cyc_o, bus.wbm2_cyc_o, bus.wbm1_cyc_o};
  assign m_stb = {bus.wbm4_stb_o, bus.wbm3_stb_o, bus.wbm2_stb_o, bus.wbm1_stb_o};
  assign m_we  = {bus.wbm4_we_o,  bus.wbm3_we_o,  bus.wbm2_we_o,  bus.wbm1_we_o};
  assign m_sel[0] = bus.wbm1_sel_o;  assign m_adr[0] = bus.wbm1_adr_o;  assign m_dat[0] = bus.wbm1_dat_o;
  assign m_sel[1] = bus.wbm2_sel_o;  assign m_adr[1] = bus.wbm2_adr_o;  assign m_dat[1] = bus.wbm2_dat_o;
  assign m_sel[2] = bus.wbm3_sel_o;  assign m_adr[2] = bus.wbm3_adr_o;  assign m_dat[2] = bus.wbm3_dat_o;
  assign m_sel[3] = bus.wbm4_sel_o;  assign m_adr[3] = bus.wbm4_adr_o;  assign m_dat[3] = bus.wbm4_dat_o;
  assign bus.wbm1_ack_i = s_ack[0];  assign bus.wbm1_dat_i = s_dat[0];
  assign bus.wbm2_ack_i = s_ack[1];  assign bus.wbm2_dat_i = s_dat[1];
  assign bus.wbm3_ack_i = s_ack[2];  assign bus.wbm3_dat_i = s_dat[2];
  assign bus.wbm4_ack_i = s_ack[3];  assign bus.wbm4_dat_i = s_dat[3];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: which window the address lands in (first match), -1 if none.
  function automatic int ref_target(input logic [31:0] adr);
    for (int i = 0; i < 4; i++)
      if ((adr & MASKS[i]) == BASES[i]) return i;
    return -1;
  endfunction

  // Reference response {err, latency from request, downstream strobe length, read data}.
  function automatic logic [EW-1:0] ref_resp(input logic [31:0] adr, input logic we,
                                             input int delay, input logic [31:0] rdata);
    if (ref_target(adr) < 0)
      return {7'd0, 1'b1, 8'd1, 8'd0, ERR_DAT};
    if (delay < TIMEOUT)
      return {7'd0, 1'b0, 8'(delay + 2), 8'(delay + 1), (we ? 32'h0 : rdata)};
    return {7'd0, 1'b1, 8'(TIMEOUT + 1), 8'(TIMEOUT), ERR_DAT};
  endfunction

  function automatic logic [31:0] out_or();
    logic [31:0] r;
    r = bus.wbs_dat_o | {30'd0, bus.wbs_ack_o, bus.wbs_err_o};
    for (int n = 0; n < 4; n++)
      r |= m_adr[n] | m_dat[n] | {24'd0, m_sel[n], m_cyc[n], m_stb[n], m_we[n], 1'b0};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // One upstream cycle; the target slave acks `delay` cycles after its first strobe cycle
  // (delay >= TIMEOUT means never). Non-target slaves raise random stray acks.
  task automatic do_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] wdat, input int delay, input logic [31:0] rdata);
    logic [EW-1:0] e;
    logic [31:0]   got_dat;
    logic          got_err;
    int tgt, strobes, stray, lat;
    bit seen;
    tgt = ref_target(adr);
    exp_q.push_back(ref_resp(adr, we, delay, rdata));
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = wdat;
    strobes = 0; stray = 0; lat = 0; seen = 0; got_dat = '0; got_err = 1'b0;
    for (int k = 1; k <= 24 && !seen; k++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        seen = 1; lat = k; got_dat = bus.wbs_dat_o; got_err = bus.wbs_err_o;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        s_ack = '0;
        if (tgt >= 0) check_eq("cyc_drop_at_ack", 32'(m_cyc[tgt]), 32'd0);
      end else begin
        if (bus.wbs_err_o) stray++;
        for (int n = 0; n < 4; n++) begin
          if (n != tgt && (m_cyc[n] || m_stb[n])) stray++;
          s_dat[n] = $urandom();
          s_ack[n] = (n != tgt) && ($urandom_range(0, 3) == 0);
        end
        if (tgt >= 0 && m_cyc[tgt]) begin
          strobes++;
          if (m_stb[tgt] !== 1'b1) stray++;
          if (strobes == 1) begin
            check_eq("strobe_latency", 32'(k), 32'd1);
            check_eq("dn_adr", m_adr[tgt], adr);
            check_eq("dn_dat", m_dat[tgt], wdat);
            check_eq("dn_sel_we", {27'd0, m_sel[tgt], m_we[tgt]}, {27'd0, sel, we});
          end
          if (strobes - 1 == delay) begin
            s_ack[tgt] = 1'b1;
            s_dat[tgt] = rdata;
          end
        end
      end
    end
    s_ack = '0;
    e = exp_q.pop_front();
    check_eq("ack_seen", 32'(seen), 32'd1);
    check_eq("ack_latency", 32'(lat), {24'd0, e[47:40]});
    check_eq("err", 32'(got_err), {31'd0, e[48]});
    check_eq("rdata", got_dat, e[31:0]);
    check_eq("strobe_len", 32'(strobes), {24'd0, e[39:32]});
    check_eq("stray_activity", 32'(stray), 32'd0);
    @(negedge clk);
    check_eq("ack_one_cycle", {30'd0, bus.wbs_ack_o, bus.wbs_err_o}, 32'd0);
    check_eq("dat_hold", bus.wbs_dat_o, got_dat);
  endtask

  // Upstream drops cyc three cycles into ISSUE; a late slave ack must be ignored.
  task automatic do_abort(input logic [31:0] adr);
    int tgt, acks;
    tgt = ref_target(adr);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = adr;
    repeat (3) @(negedge clk);
    check_eq("abort_cyc_before", 32'(m_cyc[tgt]), 32'd1);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    check_eq("abort_cyc_drop", {28'd0, m_cyc}, 32'd0);
    acks = int'(bus.wbs_ack_o) + int'(bus.wbs_err_o);
    s_ack[tgt] = 1'b1; s_dat[tgt] = 32'h5555_AAAA;
    repeat (5) begin
      @(negedge clk);
      s_ack = '0;
      acks += int'(bus.wbs_ack_o) + int'(bus.wbs_err_o);
    end
    check_eq("abort_no_ack", 32'(acks), 32'd0);
  endtask

  // Reset pulsed mid-ISSUE: everything zero next edge, late slave ack produces nothing.
  task automatic do_reset(input logic [31:0] adr);
    int tgt, acks;
    tgt = ref_target(adr);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = 32'h0BAD_F00D; bus.wbs_sel_i = 4'hF;
    @(negedge clk);
    check_eq("rst_pre_cyc", 32'(m_cyc[tgt]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_outputs", out_or(), 32'd0);
    check_eq("rst_mid_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    s_ack[tgt] = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      s_ack = '0;
      acks += int'(bus.wbs_ack_o) + int'(bus.wbs_err_o);
    end
    check_eq("rst_no_ack", 32'(acks), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] adr;
    int region;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    s_ack = '0;
    for (int n = 0; n < 4; n++) s_dat[n] = '0;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", out_or(), 32'd0);
    check_eq("reset_state", 32'(dbg_state), 32'd0);
    check_eq("reset_timer", 32'(dbg_timer), 32'd0);
    rst = 1'b0;

    do_txn(32'h1000_0040, 1'b0, 4'hF, 32'h0, 2, 32'h1234_5678);
    do_txn(32'h3000_0000, 1'b1, 4'b0011, 32'hA5A5_A5A5, 1, 32'h7777_7777);
    do_txn(32'h8000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h1111_1111);
    do_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 255, 32'h2222_2222);
    do_txn(32'h0000_0104, 1'b0, 4'hF, 32'h0, 0, 32'hCAFE_F00D);
    do_txn(32'h2000_0010, 1'b0, 4'hF, 32'h0, TIMEOUT - 1, 32'h3333_4444);
    do_txn(32'h1000_0020, 1'b1, 4'hC, 32'h9999_0000, TIMEOUT, 32'h0);
    do_abort(32'h1000_0000);
    do_reset(32'h2000_0100);
    do_txn(32'h3000_0008, 1'b0, 4'hF, 32'h0, 0, 32'hFACE_B00C);

    for (int i = 0; i < 40; i++) begin
      region = $urandom_range(0, 4);
      adr    = $urandom();
      if (region < 4) adr[31:28] = 4'(region);
      else            adr[31:28] = 4'($urandom_range(4, 15));
      do_txn(adr, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom(),
             $urandom_range(0, 10), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
